// File: rtl/ld_abs16_mem_sequencer.sv
// Absolute-address LD microcode sequencer: (a16) load/store of 1 or 2 bytes.
// Optional debug status outputs o_Busy/o_Mcycle under LDABS_STATUS_EN.
module ld_abs16_mem_sequencer #(
  parameter int DATA_BYTES = 2,
  parameter int REG_SEL_W  = 3
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Active,
  input  logic                 i_Start,
  input  logic                 i_Load,
  input  logic [REG_SEL_W-1:0] i_Reg_Sel,
  input  logic [3:0]           i_Cycle_Step,
  output logic [REG_SEL_W-1:0] o_Reg_Sel,
  output logic                 o_Addr_PC,
  output logic                 o_Addr_WZ,
  output logic                 o_Inc16,
  output logic                 o_Bus_In,
  output logic                 o_Bus_Out,
  output logic                 o_Write_Z,
  output logic                 o_Write_W,
  output logic [1:0]           o_Reg_Wr,
  output logic [1:0]           o_Reg_Rd,
  output logic                 o_IR_Fetch,
  output logic                 o_Done
`ifdef LDABS_STATUS_EN
  ,
  output logic                 o_Busy,
  output logic [2:0]           o_Mcycle
`endif
);

  generate
    if (DATA_BYTES != 1 && DATA_BYTES != 2) begin : g_bad_bytes
      $error("DATA_BYTES must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IMM_LO  = 3'd1,
    S_IMM_HI  = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_FETCH   = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [REG_SEL_W-1:0] sel_q;
  logic                 load_q;
  logic                 adv, take, en;
  logic                 addr_ph, data_ph;
  logic                 data_hi;

  assign adv     = i_Cycle_Step[3];
  assign addr_ph = i_Cycle_Step[1];
  assign data_ph = i_Cycle_Step[0];
  assign take    = (state == S_IDLE) && i_Active && i_Start && adv;
  assign en      = i_Active && !i_Reset;
  assign data_hi = (state == S_DATA_HI);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state  <= S_IDLE;
      sel_q  <= '0;
      load_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        sel_q  <= i_Reg_Sel;
        load_q <= i_Load;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (take) state_nx = S_IMM_LO;
      S_IMM_LO:  if (adv)  state_nx = S_IMM_HI;
      S_IMM_HI:  if (adv)  state_nx = S_DATA_LO;
      S_DATA_LO: if (adv)  state_nx = (DATA_BYTES == 2) ? S_DATA_HI : S_FETCH;
      S_DATA_HI: if (adv)  state_nx = S_FETCH;
      S_FETCH:   if (adv)  state_nx = S_IDLE;
      default:             state_nx = S_IDLE;
    endcase
    // losing ownership of the control word aborts the sequence
    if (!i_Active) state_nx = S_IDLE;
  end

  always_comb begin
    o_Reg_Sel  = '0;
    o_Addr_PC  = 1'b0;
    o_Addr_WZ  = 1'b0;
    o_Inc16    = 1'b0;
    o_Bus_In   = 1'b0;
    o_Bus_Out  = 1'b0;
    o_Write_Z  = 1'b0;
    o_Write_W  = 1'b0;
    o_Reg_Wr   = 2'b00;
    o_Reg_Rd   = 2'b00;
    o_IR_Fetch = 1'b0;
    o_Done     = 1'b0;
    if (en) begin
      case (state)
        S_IMM_LO, S_IMM_HI: begin
          o_Reg_Sel = sel_q;
          o_Addr_PC = addr_ph;
          o_Inc16   = addr_ph;
          o_Bus_In  = data_ph;
          o_Write_Z = data_ph && (state == S_IMM_LO);
          o_Write_W = data_ph && (state == S_IMM_HI);
        end
        S_DATA_LO, S_DATA_HI: begin
          o_Reg_Sel = sel_q;
          o_Addr_WZ = addr_ph;
          o_Inc16   = addr_ph;
          o_Bus_In  = data_ph && load_q;
          o_Bus_Out = data_ph && !load_q;
          if (data_ph && load_q)  o_Reg_Wr = data_hi ? 2'b10 : 2'b01;
          if (data_ph && !load_q) o_Reg_Rd = data_hi ? 2'b10 : 2'b01;
        end
        S_FETCH: begin
          o_Reg_Sel  = sel_q;
          o_IR_Fetch = 1'b1;
          o_Done     = adv;
        end
        default: ;
      endcase
    end
  end

`ifdef LDABS_STATUS_EN
  always_comb begin
    o_Busy   = 1'b0;
    o_Mcycle = 3'd0;
    if (en && state != S_IDLE) begin
      o_Busy   = 1'b1;
      o_Mcycle = 3'(state);
    end
  end
`endif

endmodule

// File: tb/tb_ld_abs16_mem_sequencer.sv
// Scoreboard bench for ld_abs16_mem_sequencer (1-byte and 2-byte instances).
// Status outputs are checked when LDABS_STATUS_EN is defined.
module tb_ld_abs16_mem_sequencer;

  localparam logic [15:0] P_PC   = 16'h1000;
  localparam logic [15:0] P_WZ   = 16'h0800;
  localparam logic [15:0] P_INC  = 16'h0400;
  localparam logic [15:0] P_BIN  = 16'h0200;
  localparam logic [15:0] P_BOUT = 16'h0100;
  localparam logic [15:0] P_Z    = 16'h0080;
  localparam logic [15:0] P_W    = 16'h0040;
  localparam logic [15:0] P_WRHI = 16'h0020;
  localparam logic [15:0] P_WRLO = 16'h0010;
  localparam logic [15:0] P_RDHI = 16'h0008;
  localparam logic [15:0] P_RDLO = 16'h0004;
  localparam logic [15:0] P_IRF  = 16'h0002;
  localparam logic [15:0] P_DN   = 16'h0001;
  localparam logic [15:0] Z16    = 16'h0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       act2, act1;
  logic       start, load;
  logic [2:0] sel;
  logic [3:0] step;

  logic [2:0] sel2, sel1;
  logic       pc2, wz2, inc2, bin2, bout2, z2, w2, irf2, dn2;
  logic       pc1, wz1, inc1, bin1, bout1, z1, w1, irf1, dn1;
  logic [1:0] wr2, rd2, wr1, rd1;
  logic [15:0] obs2, obs1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [15:0] e2;
    logic [15:0] e1;
    logic [3:0]  s2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

`ifdef LDABS_STATUS_EN
  logic       busy2, busy1;
  logic [2:0] mc2, mc1;
`endif

  ld_abs16_mem_sequencer #(.DATA_BYTES(2), .REG_SEL_W(3)) dut2 (
    .i_Clk(clk), .i_Reset(rst), .i_Active(act2), .i_Start(start),
    .i_Load(load), .i_Reg_Sel(sel), .i_Cycle_Step(step),
    .o_Reg_Sel(sel2), .o_Addr_PC(pc2), .o_Addr_WZ(wz2), .o_Inc16(inc2),
    .o_Bus_In(bin2), .o_Bus_Out(bout2), .o_Write_Z(z2), .o_Write_W(w2),
    .o_Reg_Wr(wr2), .o_Reg_Rd(rd2), .o_IR_Fetch(irf2), .o_Done(dn2)
`ifdef LDABS_STATUS_EN
    , .o_Busy(busy2), .o_Mcycle(mc2)
`endif
  );

  ld_abs16_mem_sequencer #(.DATA_BYTES(1), .REG_SEL_W(3)) dut1 (
    .i_Clk(clk), .i_Reset(rst), .i_Active(act1), .i_Start(start),
    .i_Load(load), .i_Reg_Sel(sel), .i_Cycle_Step(step),
    .o_Reg_Sel(sel1), .o_Addr_PC(pc1), .o_Addr_WZ(wz1), .o_Inc16(inc1),
    .o_Bus_In(bin1), .o_Bus_Out(bout1), .o_Write_Z(z1), .o_Write_W(w1),
    .o_Reg_Wr(wr1), .o_Reg_Rd(rd1), .o_IR_Fetch(irf1), .o_Done(dn1)
`ifdef LDABS_STATUS_EN
    , .o_Busy(busy1), .o_Mcycle(mc1)
`endif
  );

  assign obs2 = {sel2, pc2, wz2, inc2, bin2, bout2, z2, w2,
                 wr2, rd2, irf2, dn2};
  assign obs1 = {sel1, pc1, wz1, inc1, bin1, bout1, z1, w1,
                 wr1, rd1, irf1, dn1};

  function automatic logic [15:0] sw(input logic [2:0] s);
    return {s, 13'b0};
  endfunction

  // monitor: one expected entry per driven cycle, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs2 !== e.e2) begin
        errors++;
        $display("FAIL %s dut2 got %h want %h", e.nm, obs2, e.e2);
      end
      checks++;
      if (obs1 !== e.e1) begin
        errors++;
        $display("FAIL %s dut1 got %h want %h", e.nm, obs1, e.e1);
      end
`ifdef LDABS_STATUS_EN
      checks++;
      if ({busy2, mc2} !== e.s2) begin
        errors++;
        $display("FAIL %s status2 got %h want %h", e.nm, {busy2, mc2}, e.s2);
      end
      checks++;
      if ({busy1, mc1} !== 4'h0 && act1 == 1'b0) begin
        errors++;
        $display("FAIL %s status1 got %h want 0", e.nm, {busy1, mc1});
      end
`endif
    end
  end

  task automatic cyc(input string nm, input logic [3:0] st,
                     input logic [15:0] e2, input logic [15:0] e1,
                     input logic [3:0] s2);
    exp_t e;
    step = st;
    e.nm = nm;
    e.e2 = e2;
    e.e1 = e1;
    e.s2 = s2;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic mcyc(input string nm,
                      input logic [15:0] a2, input logic [15:0] d2,
                      input logic [15:0] r2, input logic [15:0] l2,
                      input logic [15:0] a1, input logic [15:0] d1,
                      input logic [15:0] r1, input logic [15:0] l1,
                      input logic [3:0] s2);
    cyc({nm, ".a"},  4'b0010, a2, a1, s2);
    cyc({nm, ".d"},  4'b0001, d2, d1, s2);
    cyc({nm, ".t3"}, 4'b0100, r2, r1, s2);
    cyc({nm, ".t4"}, 4'b1000, l2, l1, s2);
  endtask

  initial begin
    logic [15:0] s;
    exp_t e;
    rst = 1'b1; act2 = 1'b1; act1 = 1'b1;
    start = 1'b1; load = 1'b1; sel = 3'd6; step = 4'b1000;
    @(posedge clk); #1;
    cyc("reset0", 4'b1000, Z16, Z16, 4'h0);
    rst = 1'b0;
    start = 1'b0;
    cyc("idle0", 4'b1000, Z16, Z16, 4'h0);

    // 2-byte store of SP
    act2 = 1'b1; act1 = 1'b0; load = 1'b0; sel = 3'd3; start = 1'b1;
    s = sw(3'd3);
    cyc("t1.go", 4'b1000, Z16, Z16, 4'h0);
    start = 1'b0; sel = 3'd0; load = 1'b1;
    mcyc("t1.m1", s|P_PC|P_INC, s|P_BIN|P_Z, s, s, Z16, Z16, Z16, Z16, 4'h9);
    mcyc("t1.m2", s|P_PC|P_INC, s|P_BIN|P_W, s, s, Z16, Z16, Z16, Z16, 4'hA);
    mcyc("t1.m3", s|P_WZ|P_INC, s|P_BOUT|P_RDLO, s, s,
         Z16, Z16, Z16, Z16, 4'hB);
    mcyc("t1.m4", s|P_WZ|P_INC, s|P_BOUT|P_RDHI, s, s,
         Z16, Z16, Z16, Z16, 4'hC);
    mcyc("t1.m5", s|P_IRF, s|P_IRF, s|P_IRF, s|P_IRF|P_DN,
         Z16, Z16, Z16, Z16, 4'hD);
    cyc("t1.idle", 4'b1000, Z16, Z16, 4'h0);

    // 1-byte load into A
    act2 = 1'b0; act1 = 1'b1; load = 1'b1; sel = 3'd7; start = 1'b1;
    s = sw(3'd7);
    cyc("t2.go", 4'b1000, Z16, Z16, 4'h0);
    start = 1'b0; load = 1'b0;
    mcyc("t2.m1", Z16, Z16, Z16, Z16, s|P_PC|P_INC, s|P_BIN|P_Z, s, s, 4'h0);
    mcyc("t2.m2", Z16, Z16, Z16, Z16, s|P_PC|P_INC, s|P_BIN|P_W, s, s, 4'h0);
    mcyc("t2.m3", Z16, Z16, Z16, Z16, s|P_WZ|P_INC, s|P_BIN|P_WRLO, s, s,
         4'h0);
    mcyc("t2.m4", Z16, Z16, Z16, Z16, s|P_IRF, s|P_IRF, s|P_IRF,
         s|P_IRF|P_DN, 4'h0);
    cyc("t2.idle", 4'b1000, Z16, Z16, 4'h0);

    // 2-byte load with start held high the whole time
    act2 = 1'b1; act1 = 1'b0; load = 1'b1; sel = 3'd2; start = 1'b1;
    s = sw(3'd2);
    cyc("t3.go", 4'b1000, Z16, Z16, 4'h0);
    sel = 3'd5; load = 1'b0;
    mcyc("t3.m1", s|P_PC|P_INC, s|P_BIN|P_Z, s, s, Z16, Z16, Z16, Z16, 4'h9);
    mcyc("t3.m2", s|P_PC|P_INC, s|P_BIN|P_W, s, s, Z16, Z16, Z16, Z16, 4'hA);
    mcyc("t3.m3", s|P_WZ|P_INC, s|P_BIN|P_WRLO, s, s,
         Z16, Z16, Z16, Z16, 4'hB);
    mcyc("t3.m4", s|P_WZ|P_INC, s|P_BIN|P_WRHI, s, s,
         Z16, Z16, Z16, Z16, 4'hC);
    mcyc("t3.m5", s|P_IRF, s|P_IRF, s|P_IRF, s|P_IRF|P_DN,
         Z16, Z16, Z16, Z16, 4'hD);
    load = 1'b1; sel = 3'd2;
    cyc("t3.restart", 4'b1000, Z16, Z16, 4'h0);
    start = 1'b0;
    mcyc("t3.m1b", s|P_PC|P_INC, s|P_BIN|P_Z, s, s, Z16, Z16, Z16, Z16, 4'h9);
    mcyc("t3.m2b", s|P_PC|P_INC, s|P_BIN|P_W, s, s, Z16, Z16, Z16, Z16, 4'hA);

    // abort in DATA_LO address phase
    act2 = 1'b0;
    cyc("t4.drop", 4'b0010, Z16, Z16, 4'h0);
    act2 = 1'b1;
    cyc("t4.idle.d",  4'b0001, Z16, Z16, 4'h0);
    cyc("t4.idle.t3", 4'b0100, Z16, Z16, 4'h0);
    cyc("t4.idle.t4", 4'b1000, Z16, Z16, 4'h0);

    // async reset in IMM_HI
    load = 1'b0; sel = 3'd5; start = 1'b1;
    s = sw(3'd5);
    cyc("t5.go", 4'b1000, Z16, Z16, 4'h0);
    start = 1'b0;
    mcyc("t5.m1", s|P_PC|P_INC, s|P_BIN|P_Z, s, s, Z16, Z16, Z16, Z16, 4'h9);
    step = 4'b0010;
    e.nm = "t5.rst_async"; e.e2 = Z16; e.e1 = Z16; e.s2 = 4'h0;
    sb.push_back(e);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step = 4'b0001;
    e.nm = "t5.rst_rel"; e.e2 = Z16; e.e1 = Z16; e.s2 = 4'h0;
    sb.push_back(e);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    cyc("t5.hold.t3", 4'b0100, Z16, Z16, 4'h0);
    cyc("t5.hold.t4", 4'b1000, Z16, Z16, 4'h0);
    mcyc("t5.idle", Z16, Z16, Z16, Z16, Z16, Z16, Z16, Z16, 4'h0);

    // 1-byte store
    act2 = 1'b0; act1 = 1'b1; load = 1'b0; sel = 3'd1; start = 1'b1;
    s = sw(3'd1);
    cyc("t6.go", 4'b1000, Z16, Z16, 4'h0);
    start = 1'b0; sel = 3'd4;
    mcyc("t6.m1", Z16, Z16, Z16, Z16, s|P_PC|P_INC, s|P_BIN|P_Z, s, s, 4'h0);
    mcyc("t6.m2", Z16, Z16, Z16, Z16, s|P_PC|P_INC, s|P_BIN|P_W, s, s, 4'h0);
    mcyc("t6.m3", Z16, Z16, Z16, Z16, s|P_WZ|P_INC, s|P_BOUT|P_RDLO, s, s,
         4'h0);
    mcyc("t6.m4", Z16, Z16, Z16, Z16, s|P_IRF, s|P_IRF, s|P_IRF,
         s|P_IRF|P_DN, 4'h0);
    cyc("t6.idle", 4'b1000, Z16, Z16, 4'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
